// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: the read-return tracking
// state encoding and the default bus widths / host starvation limit.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 4;

    // Which side, if any, owns the read data returning this cycle.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RET_CORE = 2'd1,
        RET_HOST = 2'd2
    } ret_state_e;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous-read data memory port between the CPU datapath
// (core) and an external host. The core wins ties unless the host has been
// turned away MAX_WAIT cycles in a row. Read data comes back one cycle after
// issue and is steered to the side that issued it; a new access may be
// issued in that same return cycle.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   core_req/we/addr/wdata     core access request
//   core_stall                 hold datapath (denied, or load issue cycle)
//   core_rvalid/rdata          core load return
//   host_valid/we/addr/wdata   host access request
//   host_ready                 host request accepted this cycle
//   host_rvalid/rdata          host read return
//   mem_en/we/addr/wdata       memory access (combinational from grant)
//   mem_rdata                  memory read data, one cycle after a read
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    ret_state_e r_state;
    ret_state_e w_state_nxt;
    logic [3:0] r_wait_cnt;

    logic w_core_pend;
    logic w_host_pend;
    logic w_host_prio;
    logic w_gnt_core;
    logic w_gnt_host;

    // Requests are masked while reset is held so nothing reaches the memory
    // and the core is not stalled. In the core's return cycle its request is
    // the one already being answered, so it is not pending again.
    assign w_core_pend = reset && core_req && (r_state != RET_CORE);
    assign w_host_pend = reset && host_valid;
    assign w_host_prio = (r_wait_cnt == LP_MAX_WAIT);

    assign w_gnt_host  = w_host_pend && (!w_core_pend || w_host_prio);
    assign w_gnt_core  = w_core_pend && !w_gnt_host;

    // A granted store finishes in place; a granted load stalls for its issue
    // cycle; a denied request stalls until it is granted.
    assign core_stall  = w_core_pend && !(w_gnt_core && core_we);
    assign host_ready  = w_gnt_host;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt_core) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (w_gnt_host) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (w_gnt_core && !core_we)
            w_state_nxt = RET_CORE;
        else if (w_gnt_host && !host_we)
            w_state_nxt = RET_HOST;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Consecutive host denials; saturates so the host keeps priority until
    // it is actually served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_wait_cnt <= '0;
        else if (w_gnt_host)
            r_wait_cnt <= '0;
        else if (host_valid && (r_wait_cnt != LP_MAX_WAIT))
            r_wait_cnt <= r_wait_cnt + 4'd1;
    end

    // The return flags are decoded straight from the state register, so they
    // are registered and mutually exclusive by construction.
    assign core_rvalid = (r_state == RET_CORE);
    assign host_rvalid = (r_state == RET_HOST);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001: Parameter ADDR_W, 32, address width of the data memory port.
- REQ-002: Parameter DATA_W, 32, data width of all data buses.
- REQ-003: Parameter MAX_WAIT, 4, consecutive host denials after which the host gets priority; range 1..15.
- REQ-004: Ports SHALL be as follows:
  - clk  in  1  single clock; all state on its rising edge.
  - reset  in  1  asynchronous, active-low reset.
  - core_req  in  1  datapath requests a load or store this cycle.
  - core_we  in  1  1 = store, 0 = load.
  - core_addr  in  ADDR_W  core address.
  - core_wdata  in  DATA_W  core store data.
  - core_stall  out  1  holds the datapath PC and register write.
  - core_rvalid  out  1  core_rdata valid.
  - core_rdata  out  DATA_W  load data.
  - host_valid  in  1  host request valid.
  - host_we  in  1  host write.
  - host_addr  in  ADDR_W  host address.
  - host_wdata  in  DATA_W  host write data.
  - host_ready  out  1  host request accepted this cycle.
  - host_rvalid  out  1  host_rdata valid.
  - host_rdata  out  DATA_W  host read data.
  - mem_en  out  1  memory access strobe.
  - mem_we  out  1  memory write.
  - mem_addr  out  ADDR_W  memory address.
  - mem_wdata  out  DATA_W  memory write data.
  - mem_rdata  in  DATA_W  read data, valid the cycle after mem_en && !mem_we.

Function
- REQ-005: The memory port SHALL carry at most one access per cycle; the mem_* outputs are combinational from the grant.
- REQ-006: A core request is pending when core_req=1 and the core is not in its read-return cycle (REQ-010).
- REQ-007: Arbitration when both sides are pending SHALL go to the core, unless wait_cnt==MAX_WAIT, in which case it goes to the host.
- REQ-008: If only one side is pending, that side SHALL be granted.
- REQ-009: wait_cnt SHALL update as follows:
  - increment, saturating at MAX_WAIT, each cycle host_valid=1 and host_ready=0;
  - clear on a host grant;
  - hold otherwise.
- REQ-010: Core load sequence:
  - issue cycle N: core_stall=1;
  - cycle N+1: core_rvalid=1, core_rdata=mem_rdata, core_stall=0;
  - core_req in cycle N+1 is treated as already satisfied and SHALL NOT be re-issued.
- REQ-011: Core store SHALL complete in the grant cycle with core_stall=0.
- REQ-012: A denied core request SHALL see core_stall=1 for every denied cycle.
- REQ-013: host_ready SHALL equal the host grant; a host transfer occurs when host_valid && host_ready.
- REQ-014: A host read accepted in cycle N SHALL produce host_rvalid=1 with host_rdata in cycle N+1; the host cannot back-pressure.
- REQ-015: A new access (either side) MAY be issued in the same cycle a previous read returns (back-to-back, no bubble).
- REQ-016: The return-tracking FSM SHALL have three states:
  - IDLE;
  - RET_CORE (a core read is in flight);
  - RET_HOST (a host read is in flight).
- REQ-017: The next FSM state SHALL be set by the current cycle's granted read; IDLE if there is no read grant.
- REQ-018: core_rvalid and host_rvalid SHALL be registered flags, never both 1.
- REQ-019: core_rdata and host_rdata SHALL be zero when their valid flag is 0.
- REQ-020: With no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata are don't-care but SHALL be driven to 0.

Reset
- REQ-021: On reset=0, asynchronously:
  - state=IDLE;
  - wait_cnt=0;
  - core_rvalid=0 and host_rvalid=0;
  - all data outputs 0.
- REQ-022: While in reset, core_stall=0, host_ready=0 and mem_en=0.
- REQ-023: A read in flight when reset asserts SHALL be dropped; no rvalid follows deassertion.
- REQ-024: The first grant SHALL be possible in the first clock edge after reset deasserts.

Structure
- REQ-025: A shared package dmem_arb_pkg SHALL hold the state enum (IDLE, RET_CORE, RET_HOST) and the default ADDR_W, DATA_W and MAX_WAIT constants.
- REQ-026: The block SHALL be a single module; no sub-module is needed.
- REQ-027: The memory SHALL be external and have synchronous read.

Verification
- REQ-028: Core load, address 0x10, memory holds 0xDEADBEEF, host idle: core_stall=1 in cycle N, then core_rvalid=1 with core_rdata=0xDEADBEEF and core_stall=0 in cycle N+1.
- REQ-029: Simultaneous core store (0x20←0x5) and host read (0x24): core granted first, host_ready=0; host is granted the next cycle; host_rdata is valid one cycle after that.
- REQ-030: Core requests every cycle, host_valid held high, MAX_WAIT=4: host_ready=1 on the 5th cycle; wait_cnt then returns to 0; core_stall=1 in that cycle.
- REQ-031: Back-to-back traffic: host read of 0x0 followed by core load of 0x4: mem_en stays high in consecutive cycles and each rvalid goes to the correct side.
- REQ-032: reset asserted in the cycle after a core load is issued: no core_rvalid occurs; outputs are 0; normal operation resumes after deassertion.
- REQ-033: Host write to 0x8 with core idle: host_ready=1 and mem_we=1 in the same cycle; no host_rvalid follows.
